// File: rtl/cntr_bank_arb.sv
// -----------------------------------------------------------------------------
// cntr_bank_arb
//
// Channel-level arbiter and read/write mode controller. Each cycle it picks
// one bank scheduler with a pending request (round-robin) and moves that
// request into a single-entry output register. It also owns the channel-wide
// read/write mode: write mode is entered on a high watermark of queued writes
// (or when reads are idle but writes are waiting) and left on a low watermark
// or after a maximum dwell time. Every mode switch waits for the output
// register to drain and then inserts a fixed turnaround bubble.
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst_n      in   asynchronous active-low reset
//   valid_i    in   [BANKS]          per-bank request valid
//   req_i      in   [BANKS*REQ_W]    per-bank request, bank b at [b*REQ_W +: REQ_W]
//   num_i      in   [BANKS*WR_BITS]  per-bank write count, bank b at [b*WR_BITS +: WR_BITS]
//   ready_o    out  [BANKS]          one-hot pop to the granted bank (combinational)
//   mode       out  1 = write mode, 0 = read mode
//   valid_o    out  output register holds a request
//   req_o      out  [REQ_W]          registered request {t, ra, ca, idx, dq}
//   bank_o     out  [BW]             source bank of req_o
//   ready_i    in   downstream accepts req_o
//   fsm_state  out  [2]              mode FSM state (debug visibility)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Upstream: ready_o[b] is only raised while valid_i[b] is high,
// and the bank pops its request on that edge. Downstream: req_o/bank_o stay
// stable while valid_o=1 and ready_i=0; on valid_o & ready_i the entry is
// consumed and may be replaced by a new grant on the same edge.
// -----------------------------------------------------------------------------
module cntr_bank_arb #(
    parameter int BANKS    = 4,
    parameter int DQ       = 16,
    parameter int IDX      = 7,
    parameter int RA       = 16,
    parameter int CA       = 10,
    parameter int WR_BITS  = 3,
    parameter int HI_WM    = 6,
    parameter int LO_WM    = 1,
    parameter int WR_MAX   = 32,
    parameter int TURN_CYC = 2,
    localparam int REQ_W   = DQ + IDX + RA + CA + 1,
    localparam int SUM_W   = WR_BITS + $clog2(BANKS),
    localparam int BW      = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [BANKS-1:0]           valid_i,
    input  logic [BANKS*REQ_W-1:0]     req_i,
    input  logic [BANKS*WR_BITS-1:0]   num_i,
    output logic [BANKS-1:0]           ready_o,
    output logic                       mode,
    output logic                       valid_o,
    output logic [REQ_W-1:0]           req_o,
    output logic [BW-1:0]              bank_o,
    input  logic                       ready_i,
    output logic [1:0]                 fsm_state
);

    // -------------------------------------------------------------------------
    // Local constants, sized to the signals they are compared against
    // -------------------------------------------------------------------------
    localparam int WC_W = (WR_MAX > 1) ? $clog2(WR_MAX) : 1;
    localparam int TC_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    localparam logic [SUM_W-1:0] HI_S    = SUM_W'(HI_WM);
    localparam logic [SUM_W-1:0] LO_S    = SUM_W'(LO_WM);
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(WR_MAX - 1);
    localparam logic [TC_W-1:0]  TC_LAST = TC_W'(TURN_CYC - 1);
    localparam logic [BW:0]      BANKS_W = (BW + 1)'(BANKS);

    typedef enum logic [1:0] {
        ST_RD     = 2'd0,
        ST_WR     = 2'd1,
        ST_TURN_W = 2'd2,
        ST_TURN_R = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    state_t                 state_q;
    state_t                 state_d;
    logic [WC_W-1:0]        wcnt_q;
    logic [TC_W-1:0]        tcnt_q;
    logic [BW-1:0]          ptr_q;
    logic                   valid_q;

    logic [SUM_W-1:0]       wsum;
    logic                   switch_req;
    logic                   arb_en;
    logic                   accept;
    logic                   load;

    logic [2*BANKS-1:0]     rot;
    logic                   found;
    logic [BW-1:0]          off;
    logic [BW:0]            gsum;
    logic [BW-1:0]          gnt;
    logic [BW:0]            psum;
    logic [BW-1:0]          ptr_nxt;

    // -------------------------------------------------------------------------
    // Total queued writes across all banks
    // -------------------------------------------------------------------------
    always_comb begin
        wsum = '0;
        for (int b = 0; b < BANKS; b++) begin
            wsum = wsum + SUM_W'(num_i[b*WR_BITS +: WR_BITS]);
        end
    end

    // -------------------------------------------------------------------------
    // Mode switch request, evaluated only in the steady RD/WR states.
    // wcnt saturates at WR_MAX-1, so a dwell timeout that has to wait for the
    // output register to drain stays asserted until the switch is taken.
    // -------------------------------------------------------------------------
    always_comb begin
        switch_req = 1'b0;
        unique case (state_q)
            ST_RD:   switch_req = (wsum >= HI_S) || ((wsum != '0) && !(|valid_i));
            ST_WR:   switch_req = (wsum <= LO_S) || (wcnt_q == WC_LAST);
            default: switch_req = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Round-robin search: rotate the valid vector so ptr_q sits at bit 0,
    // take the lowest set bit, then map the offset back to a bank number.
    // -------------------------------------------------------------------------
    always_comb begin
        rot   = {valid_i, valid_i} >> ptr_q;
        found = 1'b0;
        off   = '0;
        for (int i = 0; i < BANKS; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = BW'(i);
            end
        end

        gsum = {1'b0, ptr_q} + {1'b0, off};
        if (gsum >= BANKS_W) begin
            gsum = gsum - BANKS_W;
        end
        gnt = gsum[BW-1:0];

        psum = {1'b0, gnt} + (BW + 1)'(1);
        if (psum >= BANKS_W) begin
            psum = '0;
        end
        ptr_nxt = psum[BW-1:0];
    end

    // Arbitration is frozen during reset, during turnaround and while a mode
    // switch is waiting for the output register to drain.
    assign arb_en  = rst_n && ((state_q == ST_RD) || (state_q == ST_WR)) && !switch_req;
    assign accept  = !valid_q || ready_i;
    assign load    = arb_en && accept && found;
    assign ready_o = load ? (BANKS'(1) << gnt) : '0;

    // -------------------------------------------------------------------------
    // Mode FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RD;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Mode FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RD: begin
                if (switch_req && !valid_q) begin
                    state_d = ST_TURN_W;
                end
            end
            ST_WR: begin
                if (switch_req && !valid_q) begin
                    state_d = ST_TURN_R;
                end
            end
            ST_TURN_W: begin
                if (tcnt_q == TC_LAST) begin
                    state_d = ST_WR;
                end
            end
            ST_TURN_R: begin
                if (tcnt_q == TC_LAST) begin
                    state_d = ST_RD;
                end
            end
            default: state_d = ST_RD;
        endcase
    end

    // Mode follows the target of a switch from the first turnaround cycle on.
    assign mode      = (state_q == ST_WR) || (state_q == ST_TURN_W);
    assign fsm_state = state_q;

    // -------------------------------------------------------------------------
    // Turnaround and write-dwell counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
        end else if ((state_q == ST_TURN_W) || (state_q == ST_TURN_R)) begin
            tcnt_q <= (tcnt_q == TC_LAST) ? '0 : tcnt_q + TC_W'(1);
        end else begin
            tcnt_q <= '0;
        end
    end

    // Cleared throughout TURN_W so the first WR cycle starts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q <= '0;
        end else if (state_q == ST_TURN_W) begin
            wcnt_q <= '0;
        end else if ((state_q == ST_WR) && (wcnt_q != WC_LAST)) begin
            wcnt_q <= wcnt_q + WC_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Round-robin pointer: advances past the granted bank on every load
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (load) begin
            ptr_q <= ptr_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Output register. A load on the same edge as an unload keeps valid high,
    // giving one request per cycle while ready_i stays high.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            req_o   <= '0;
            bank_o  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            req_o   <= req_i[int'(gnt)*REQ_W +: REQ_W];
            bank_o  <= gnt;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;

endmodule
